// File: rtl/floo_axi_pkg.sv
// AXI channel and bundle typedefs for the narrow and wide NoC links.
// The traffic generator drives the wide link; the narrow link shares the same channel layout.
package floo_axi_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstIncr  = 2'b01;

    localparam int unsigned WideAddrWidth = 48;
    localparam int unsigned WideDataWidth = 512;
    localparam int unsigned WideIdWidth   = 3;
    localparam int unsigned WideUserWidth = 1;

    localparam int unsigned NarrowAddrWidth = 48;
    localparam int unsigned NarrowDataWidth = 64;
    localparam int unsigned NarrowIdWidth   = 4;
    localparam int unsigned NarrowUserWidth = 1;

    typedef struct packed {
        logic [WideIdWidth-1:0]   id;
        logic [WideAddrWidth-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               qos;
        logic [3:0]               region;
        logic [5:0]               atop;
        logic [WideUserWidth-1:0] user;
    } axi_wide_aw_chan_t;

    typedef struct packed {
        logic [WideDataWidth-1:0]   data;
        logic [WideDataWidth/8-1:0] strb;
        logic                       last;
        logic [WideUserWidth-1:0]   user;
    } axi_wide_w_chan_t;

    typedef struct packed {
        logic [WideIdWidth-1:0]   id;
        logic [1:0]               resp;
        logic [WideUserWidth-1:0] user;
    } axi_wide_b_chan_t;

    typedef struct packed {
        logic [WideIdWidth-1:0]   id;
        logic [WideAddrWidth-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
        logic                     lock;
        logic [3:0]               cache;
        logic [2:0]               prot;
        logic [3:0]               qos;
        logic [3:0]               region;
        logic [WideUserWidth-1:0] user;
    } axi_wide_ar_chan_t;

    typedef struct packed {
        logic [WideIdWidth-1:0]   id;
        logic [WideDataWidth-1:0] data;
        logic [1:0]               resp;
        logic                     last;
        logic [WideUserWidth-1:0] user;
    } axi_wide_r_chan_t;

    typedef struct packed {
        axi_wide_aw_chan_t aw;
        logic              aw_valid;
        axi_wide_w_chan_t  w;
        logic              w_valid;
        logic              b_ready;
        axi_wide_ar_chan_t ar;
        logic              ar_valid;
        logic              r_ready;
    } axi_wide_req_t;

    typedef struct packed {
        logic             aw_ready;
        logic             ar_ready;
        logic             w_ready;
        logic             b_valid;
        axi_wide_b_chan_t b;
        logic             r_valid;
        axi_wide_r_chan_t r;
    } axi_wide_rsp_t;

    typedef struct packed {
        logic [NarrowIdWidth-1:0]   id;
        logic [NarrowAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [5:0]                 atop;
        logic [NarrowUserWidth-1:0] user;
    } axi_narrow_aw_chan_t;

    typedef struct packed {
        logic [NarrowDataWidth-1:0]   data;
        logic [NarrowDataWidth/8-1:0] strb;
        logic                         last;
        logic [NarrowUserWidth-1:0]   user;
    } axi_narrow_w_chan_t;

    typedef struct packed {
        logic [NarrowIdWidth-1:0]   id;
        logic [1:0]                 resp;
        logic [NarrowUserWidth-1:0] user;
    } axi_narrow_b_chan_t;

    typedef struct packed {
        logic [NarrowIdWidth-1:0]   id;
        logic [NarrowAddrWidth-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [NarrowUserWidth-1:0] user;
    } axi_narrow_ar_chan_t;

    typedef struct packed {
        logic [NarrowIdWidth-1:0]   id;
        logic [NarrowDataWidth-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
        logic [NarrowUserWidth-1:0] user;
    } axi_narrow_r_chan_t;

    typedef struct packed {
        axi_narrow_aw_chan_t aw;
        logic                aw_valid;
        axi_narrow_w_chan_t  w;
        logic                w_valid;
        logic                b_ready;
        axi_narrow_ar_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } axi_narrow_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic               b_valid;
        axi_narrow_b_chan_t b;
        logic               r_valid;
        axi_narrow_r_chan_t r;
    } axi_narrow_rsp_t;

endpackage

// File: rtl/floo_test_pkg.sv
// Shared helpers for NoC test endpoints: data pattern and saturating error counter.
package floo_test_pkg;

    localparam int unsigned ErrCntWidth = 16;

    // One 32-bit pattern word; callers replicate it across the data bus.
    function automatic logic [31:0] pattern_word(input logic [15:0] txn, input logic [15:0] beat);
        return {txn, beat};
    endfunction

    function automatic logic [ErrCntWidth-1:0] err_cnt_add(input logic [ErrCntWidth-1:0] cnt,
                                                           input logic [1:0] inc);
        logic [ErrCntWidth:0] sum;
        sum = {1'b0, cnt} + (ErrCntWidth + 1)'(inc);
        return sum[ErrCntWidth] ? {ErrCntWidth{1'b1}} : sum[ErrCntWidth-1:0];
    endfunction

endpackage

// File: rtl/floo_axi_traffic_gen.sv
// AXI traffic generator: writes NumTxns patterned bursts, reads them back and counts
// data/response errors. One transaction outstanding at a time.
module floo_axi_traffic_gen
    import floo_test_pkg::*;
#(
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          DataWidth = 512,
    parameter int unsigned          IdWidth   = 3,
    parameter int unsigned          NumTxns   = 4,
    parameter int unsigned          BurstLen  = 7,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter logic [AddrWidth-1:0] Stride    = AddrWidth'('h1000),
    parameter type                  axi_req_t = floo_axi_pkg::axi_wide_req_t,
    parameter type                  axi_rsp_t = floo_axi_pkg::axi_wide_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output axi_req_t               axi_req_o,
    input  axi_rsp_t               axi_rsp_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

    localparam logic [15:0] LastBeat = 16'(BurstLen);
    localparam logic [15:0] LastTxn  = 16'(NumTxns - 1);
    localparam logic [7:0]  AxLen    = 8'(BurstLen);
    localparam logic [2:0]  AxSize   = 3'($clog2(DataWidth / 8));

    state_e                 state_q, state_d;
    logic [15:0]            txn_q, txn_d;
    logic [15:0]            beat_q, beat_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]             err_inc;

    logic [DataWidth-1:0] exp_data;
    logic [AddrWidth-1:0] txn_addr;

    always_comb begin
        exp_data = {(DataWidth / 32){pattern_word(txn_q, beat_q)}};
        txn_addr = BaseAddr + AddrWidth'(txn_q) * Stride;
    end

    // Payloads are zero outside their channel's state, so reset and idle present an all-zero bus.
    always_comb begin
        axi_req_o = '0;
        unique case (state_q)
            StAw: begin
                axi_req_o.aw_valid = 1'b1;
                axi_req_o.aw.id    = '0;
                axi_req_o.aw.addr  = txn_addr;
                axi_req_o.aw.len   = AxLen;
                axi_req_o.aw.size  = AxSize;
                axi_req_o.aw.burst = floo_axi_pkg::BurstIncr;
            end
            StW: begin
                axi_req_o.w_valid = 1'b1;
                axi_req_o.w.data  = exp_data;
                axi_req_o.w.strb  = '1;
                axi_req_o.w.last  = (beat_q == LastBeat);
            end
            StB: axi_req_o.b_ready = 1'b1;
            StAr: begin
                axi_req_o.ar_valid = 1'b1;
                axi_req_o.ar.id    = '0;
                axi_req_o.ar.addr  = txn_addr;
                axi_req_o.ar.len   = AxLen;
                axi_req_o.ar.size  = AxSize;
                axi_req_o.ar.burst = floo_axi_pkg::BurstIncr;
            end
            StR: axi_req_o.r_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        beat_d    = beat_q;
        err_cnt_d = err_cnt_q;
        err_inc   = 2'd0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d   = StAw;
                    txn_d     = '0;
                    beat_d    = '0;
                    err_cnt_d = '0;
                end
            end
            StAw: if (axi_rsp_i.aw_ready) state_d = StW;
            StW: begin
                if (axi_rsp_i.w_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StB;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            StB: begin
                if (axi_rsp_i.b_valid) begin
                    if (axi_rsp_i.b.resp != floo_axi_pkg::RespOkay) err_inc = 2'd1;
                    if (txn_q < LastTxn) begin
                        txn_d   = txn_q + 16'd1;
                        state_d = StAw;
                    end else begin
                        txn_d   = '0;
                        state_d = StAr;
                    end
                end
            end
            StAr: if (axi_rsp_i.ar_ready) state_d = StR;
            StR: begin
                if (axi_rsp_i.r_valid) begin
                    if (axi_rsp_i.r.data != exp_data
                        || axi_rsp_i.r.resp != floo_axi_pkg::RespOkay) begin
                        err_inc = err_inc + 2'd1;
                    end
                    // A misplaced r_last is one error; only r_last ends the burst.
                    if (axi_rsp_i.r.last != (beat_q == LastBeat)) err_inc = err_inc + 2'd1;
                    if (axi_rsp_i.r.last) begin
                        beat_d = '0;
                        if (txn_q < LastTxn) begin
                            txn_d   = txn_q + 16'd1;
                            state_d = StAr;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (err_inc != 2'd0) err_cnt_d = err_cnt_add(err_cnt_q, err_inc);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            txn_q     <= '0;
            beat_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txn_q     <= txn_d;
            beat_q    <= beat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy_o    = (state_q != StIdle) && (state_q != StDone);
    assign done_o    = (state_q == StDone);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_floo_axi_traffic_gen.sv
// Bench for floo_axi_traffic_gen: a memory-model responder with random backpressure and
// fault injection, checked against the expected run computed from the generator's rules.
module tb_floo_axi_traffic_gen;
    import floo_axi_pkg::*;

    localparam int unsigned NumTxns   = 2;
    localparam int unsigned BurstLen  = 3;
    localparam int unsigned Beats     = BurstLen + 1;
    localparam int unsigned BeatBytes = 64;
    localparam logic [47:0] BaseAddr  = 48'h1000_0000;
    localparam logic [47:0] Stride    = 48'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    axi_wide_req_t req;
    axi_wide_rsp_t rsp = '0;
    logic          busy, done;
    logic [15:0]   err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    floo_axi_traffic_gen #(
        .AddrWidth (48),
        .DataWidth (512),
        .IdWidth   (3),
        .NumTxns   (NumTxns),
        .BurstLen  (BurstLen),
        .BaseAddr  (BaseAddr),
        .Stride    (Stride),
        .axi_req_t (axi_wide_req_t),
        .axi_rsp_t (axi_wide_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .axi_req_o (req),
        .axi_rsp_i (rsp),
        .busy_o    (busy),
        .done_o    (done),
        .err_cnt_o (err_cnt)
    );

    // Responder / memory model state
    int unsigned   ready_pct = 100;
    bit            corrupt_en = 0;
    bit            slverr_en = 0;
    logic [511:0]  mem [logic [47:0]];
    logic [47:0]   aw_addrs[$];
    logic [47:0]   ar_addrs[$];
    logic [47:0]   w_addr_q[$];
    logic [47:0]   r_q[$];
    int            w_beat, w_burst, r_beat, b_pending;
    int            w_beats_total, w_errs, field_errs, stab_errs, b_total, r_total;
    bit            b_fire_q, r_fire_q, aw_fire_q, ar_fire_q;
    bit            aw_stall_q, w_stall_q, ar_stall_q;
    axi_wide_req_t req_prev;

    function automatic logic [511:0] pat(input int t, input int b);
        logic [31:0] word;
        word = {t[15:0], b[15:0]};
        return {16{word}};
    endfunction

    function automatic int txn_of(input logic [47:0] addr);
        return int'((addr - BaseAddr) / Stride);
    endfunction

    always @(negedge clk) begin
        logic [47:0] a;
        bit fire;
        if (!rst_n) begin
            rsp = '0;
            w_addr_q.delete();
            r_q.delete();
            w_beat = 0; w_burst = 0; r_beat = 0; b_pending = 0;
            b_fire_q = 0; r_fire_q = 0; aw_fire_q = 0; ar_fire_q = 0;
            aw_stall_q = 0; w_stall_q = 0; ar_stall_q = 0;
        end else begin
            // Valid/payload hold while stalled; address valids drop after their handshake
            if (aw_stall_q && (req.aw_valid !== 1'b1 || req.aw !== req_prev.aw)) stab_errs++;
            if (w_stall_q && (req.w_valid !== 1'b1 || req.w !== req_prev.w)) stab_errs++;
            if (ar_stall_q && (req.ar_valid !== 1'b1 || req.ar !== req_prev.ar)) stab_errs++;
            if (aw_fire_q && req.aw_valid) stab_errs++;
            if (ar_fire_q && req.ar_valid) stab_errs++;
            if (req.w_valid && req.aw_valid) field_errs++;
            if (req.b_ready && req.r_ready) field_errs++;

            // Retire handshakes that completed on the last rising edge
            if (b_fire_q) b_pending--;
            if (r_fire_q) begin
                if (r_beat == BurstLen) begin
                    r_beat = 0;
                    void'(r_q.pop_front());
                end else begin
                    r_beat++;
                end
            end

            rsp.b_valid = (b_pending > 0);
            rsp.b = '0;
            rsp.b.resp = slverr_en ? RespSlvErr : RespOkay;
            rsp.r = '0;
            rsp.r_valid = (r_q.size() > 0);
            if (rsp.r_valid) begin
                a = r_q[0] + 48'(r_beat * BeatBytes);
                rsp.r.data = mem.exists(a) ? mem[a] : '0;
                if (corrupt_en && txn_of(r_q[0]) == 1 && r_beat == 2) rsp.r.data[0] = ~rsp.r.data[0];
                rsp.r.last = (r_beat == BurstLen);
            end
            b_fire_q = rsp.b_valid && req.b_ready;
            r_fire_q = rsp.r_valid && req.r_ready;
            if (b_fire_q) b_total++;
            if (r_fire_q) r_total++;

            rsp.aw_ready = req.aw_valid && ($urandom_range(99) < ready_pct);
            aw_fire_q = req.aw_valid && rsp.aw_ready;
            aw_stall_q = req.aw_valid && !rsp.aw_ready;
            if (aw_fire_q) begin
                aw_addrs.push_back(req.aw.addr);
                w_addr_q.push_back(req.aw.addr);
                if (req.aw.id !== 3'd0 || req.aw.len !== 8'(BurstLen) || req.aw.size !== 3'd6
                    || req.aw.burst !== BurstIncr || req.aw.cache !== 4'd0 || req.aw.prot !== 3'd0
                    || req.aw.qos !== 4'd0 || req.aw.user !== 1'b0) field_errs++;
            end

            rsp.w_ready = req.w_valid && ($urandom_range(99) < ready_pct);
            fire = req.w_valid && rsp.w_ready;
            w_stall_q = req.w_valid && !rsp.w_ready;
            if (fire) begin
                w_beats_total++;
                if (req.w.data !== pat(w_burst, w_beat) || req.w.strb !== '1
                    || req.w.last !== (w_beat == BurstLen)) w_errs++;
                if (w_addr_q.size() == 0) begin
                    w_errs++;
                end else begin
                    mem[w_addr_q[0] + 48'(w_beat * BeatBytes)] = req.w.data;
                end
                if (w_beat == BurstLen) begin
                    w_beat = 0;
                    w_burst++;
                    if (w_addr_q.size() > 0) void'(w_addr_q.pop_front());
                    b_pending++;
                end else begin
                    w_beat++;
                end
            end

            rsp.ar_ready = req.ar_valid && ($urandom_range(99) < ready_pct);
            ar_fire_q = req.ar_valid && rsp.ar_ready;
            ar_stall_q = req.ar_valid && !rsp.ar_ready;
            if (ar_fire_q) begin
                ar_addrs.push_back(req.ar.addr);
                r_q.push_back(req.ar.addr);
                if (req.ar.id !== 3'd0 || req.ar.len !== 8'(BurstLen) || req.ar.size !== 3'd6
                    || req.ar.burst !== BurstIncr || req.ar.cache !== 4'd0) field_errs++;
            end
        end
        req_prev = req;
    end

    task automatic clear_log();
        aw_addrs.delete();
        ar_addrs.delete();
        w_burst = 0;
        w_beats_total = 0; w_errs = 0; field_errs = 0; stab_errs = 0;
        b_total = 0; r_total = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: done_o=%0b after %0d cycles, required 1", name, done, n);
        end
    endtask

    // Full run from start pulse to DONE, checked against the expected transaction sequence
    task automatic do_run(input string name, input logic [15:0] exp_err);
        bit bad;
        clear_log();
        pulse_start();
        checks++;
        if (req.aw_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL %s_start: aw_valid=%0b busy=%0b done=%0b err=%0d, required 1 1 0 0",
                     name, req.aw_valid, busy, done, err_cnt);
        end
        wait_done(name);
        checks++;
        if (busy !== 1'b0 || err_cnt !== exp_err) begin
            failures++;
            $display("FAIL %s_end: busy=%0b err_cnt=%0d, required 0 %0d", name, busy, err_cnt, exp_err);
        end
        checks++;
        bad = (aw_addrs.size() != NumTxns);
        for (int i = 0; i < aw_addrs.size(); i++) if (aw_addrs[i] !== BaseAddr + 48'(i) * Stride) bad = 1;
        if (bad) begin
            failures++;
            $display("FAIL %s_aw_addr: count=%0d first=%h, required %0d from %h step %h",
                     name, aw_addrs.size(), (aw_addrs.size() > 0) ? aw_addrs[0] : 48'h0,
                     NumTxns, BaseAddr, Stride);
        end
        checks++;
        bad = (ar_addrs.size() != NumTxns);
        for (int i = 0; i < ar_addrs.size(); i++) if (ar_addrs[i] !== BaseAddr + 48'(i) * Stride) bad = 1;
        if (bad) begin
            failures++;
            $display("FAIL %s_ar_addr: count=%0d, required %0d correctly addressed", name,
                     ar_addrs.size(), NumTxns);
        end
        checks++;
        if (w_beats_total != NumTxns * Beats || w_errs != 0) begin
            failures++;
            $display("FAIL %s_w: beats=%0d bad_beats=%0d, required %0d 0", name, w_beats_total,
                     w_errs, NumTxns * Beats);
        end
        checks++;
        if (b_total != NumTxns || r_total != NumTxns * Beats) begin
            failures++;
            $display("FAIL %s_resp: b=%0d r=%0d, required %0d %0d", name, b_total, r_total,
                     NumTxns, NumTxns * Beats);
        end
        checks++;
        if (field_errs != 0 || stab_errs != 0) begin
            failures++;
            $display("FAIL %s_protocol: field_errs=%0d stability_errs=%0d, required 0 0", name,
                     field_errs, stab_errs);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req !== '0) begin
            failures++;
            $display("FAIL reset_req: request bus=%h, required all zero", req);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%0b done=%0b err=%0d, required 0 0 0", busy, done, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || req.aw_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%0b done=%0b aw_valid=%0b, required 0 0 0", busy, done,
                     req.aw_valid);
        end
    endtask

    task automatic test_basic();
        ready_pct = 100;
        do_run("basic", 16'd0);
    endtask

    task automatic test_backpressure();
        ready_pct = 30;
        do_run("backpressure", 16'd0);
        ready_pct = 100;
    endtask

    task automatic test_corruption();
        corrupt_en = 1;
        do_run("corrupt", 16'd1);
        corrupt_en = 0;
    endtask

    task automatic test_slverr();
        slverr_en = 1;
        do_run("slverr", 16'(NumTxns));
        slverr_en = 0;
    endtask

    task automatic test_busy_start();
        int n = 0;
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || err_cnt !== 16'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_restart_clear: done=%0b err=%0d busy=%0b, required 0 0 1", done,
                     err_cnt, busy);
        end
        while (req.r_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (req.aw_valid !== 1'b0 || req.r_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_ignored: aw_valid=%0b r_ready=%0b busy=%0b, required 0 1 1",
                     req.aw_valid, req.r_ready, busy);
        end
        wait_done("busy_start");
        checks++;
        if (aw_addrs.size() != NumTxns || r_total != NumTxns * Beats || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL busy_start_run: aw=%0d r=%0d err=%0d, required %0d %0d 0",
                     aw_addrs.size(), r_total, err_cnt, NumTxns, NumTxns * Beats);
        end
        do_run("rerun", 16'd0);
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        ready_pct = 100;
        clear_log();
        pulse_start();
        while (!(req.w_valid === 1'b1 && req.w.data[15:0] === 16'd1) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (req.w_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach: w_valid=%0b after %0d cycles, required 1", req.w_valid, n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req.aw_valid !== 1'b0 || req.w_valid !== 1'b0 || req.ar_valid !== 1'b0
            || req.b_ready !== 1'b0 || req.r_ready !== 1'b0 || req !== '0) begin
            failures++;
            $display("FAIL midreset_valids: aw=%0b w=%0b ar=%0b b_ready=%0b r_ready=%0b, required all 0",
                     req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_status: busy=%0b done=%0b err=%0d, required 0 0 0", busy, done, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_run("after_reset", 16'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_corruption();
        test_slverr();
        test_busy_start();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
